// File: rtl/riscv_fetch_queue.sv
// Fetch front end: owns the PC, requests imem, and queues {instr, pc, pc+4} for ID.
// Fetched instr reaches the head 1 cycle after ack; fetch stalls while full; a redirect flushes the queue.
module riscv_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     i_clk_IF,
  input  logic                     i_rstn,
  output logic [XLEN-1:0]          o_imem_addr,
  output logic                     o_imem_req,
  input  logic                     i_imem_ack,
  input  logic [XLEN-1:0]          i_imem_instr,
  input  logic                     i_redirect_valid,
  input  logic [XLEN-1:0]          i_redirect_pc,
  output logic                     o_deq_valid,
  input  logic                     i_deq_ready,
  output logic [XLEN-1:0]          o_deq_instr,
  output logic [XLEN-1:0]          o_deq_pc,
  output logic [XLEN-1:0]          o_deq_pc4,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int              PW  = $clog2(DEPTH);
  localparam int              CW  = PW + 1;
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
  } entry_t;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_plus4;
  entry_t          mem_q [DEPTH];
  entry_t          head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            redirect_lsb_unused;

  // Redirect targets are forced to word alignment, so the low bits are ignored.
  assign redirect_lsb_unused = |i_redirect_pc[1:0];

  assign pc_plus4 = pc_q + XLEN'(4);
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign head     = mem_q[rd_ptr];

  assign o_imem_addr = pc_q;
  assign o_imem_req  = i_rstn & ~full & ~i_redirect_valid;
  assign push        = o_imem_req & i_imem_ack;
  assign pop         = ~empty & i_deq_ready;

  assign o_deq_valid = ~empty;
  assign o_deq_instr = empty ? NOP : head.instr;
  assign o_deq_pc    = empty ? '0  : head.pc;
  assign o_deq_pc4   = empty ? '0  : head.pc4;
  assign o_count     = count;
  assign o_full      = full;
  assign o_empty     = empty;

  always_ff @(posedge i_clk_IF) begin
    if (push) begin
      mem_q[wr_ptr] <= '{instr: i_imem_instr, pc: pc_q, pc4: pc_plus4};
    end
  end

  always_ff @(posedge i_clk_IF) begin
    if (!i_rstn) begin
      pc_q   <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_redirect_valid) begin
      pc_q   <= {i_redirect_pc[XLEN-1:2], 2'b00};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        pc_q   <= pc_plus4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/riscv_fetch_queue.md
# riscv_fetch_queue

Parametrised instruction-fetch front end in the `i_clk_IF` domain. It owns the PC, issues requests to instruction memory, and buffers fetched instructions with their PC and PC+4 in a DEPTH-entry FIFO. This decouples IF from the ID clock domain's stalls. A redirect from EX (branch or jump) flushes the queue and restarts fetch at the target.

## Interface
- XLEN, 32, data and address width.
- DEPTH, 4, queue entries; power of two, ≥2.
- RESET_PC, 0, PC loaded on reset.
- i_clk_IF  in  1  fetch clock. All state updates on the rising edge.
- i_rstn  in  1  reset, synchronous, active-low.
- o_imem_addr  out  XLEN  fetch address; equals the PC register.
- o_imem_req  out  1  fetch request.
- i_imem_ack  in  1  memory has returned i_imem_instr for o_imem_addr this cycle.
- i_imem_instr  in  XLEN  fetched instruction, valid when i_imem_ack=1.
- i_redirect_valid  in  1  redirect PC, flush queue.
- i_redirect_pc  in  XLEN  redirect target.
- o_deq_valid  out  1  queue head valid.
- i_deq_ready  in  1  consumer takes the head.
- o_deq_instr  out  XLEN  head instruction; 32'h00000013 (NOP) when empty.
- o_deq_pc  out  XLEN  head PC; 0 when empty.
- o_deq_pc4  out  XLEN  head PC+4; 0 when empty.
- o_count  out  $clog2(DEPTH)+1  occupancy.
- o_full  out  1  count==DEPTH.
- o_empty  out  1  count==0.

## Operation
- State: pc_q (XLEN), DEPTH-entry storage of {instr, pc, pc4}, wr_ptr, rd_ptr ($clog2(DEPTH) bits, wrap modulo DEPTH), count.
- o_imem_addr = pc_q.
- o_imem_req = i_rstn & ~o_full & ~i_redirect_valid.
- o_imem_req does not depend on i_deq_ready. When full, no fetch is issued even if a pop happens that cycle.
- push = o_imem_req & i_imem_ack. On push:
  - write {i_imem_instr, pc_q, pc_q+4} at wr_ptr;
  - wr_ptr++;
  - pc_q <= pc_q+4 (modulo 2^XLEN; 0xFFFFFFFC wraps to 0).
- pop = o_deq_valid & i_deq_ready, where o_deq_valid = ~o_empty. On pop, rd_ptr++.
- count update: push only +1; pop only −1; push and pop together leave count unchanged. Pop on empty is impossible (gated by o_deq_valid).
- Redirect has priority over everything:
  - pc_q <= {i_redirect_pc[XLEN-1:2], 2'b00};
  - wr_ptr, rd_ptr and count go to 0;
  - push and pop in the same cycle are discarded (no request is issued);
  - storage contents are don't-care.
- Reset (i_rstn=0 at an edge):
  - pc_q=RESET_PC; ptrs=0; count=0.
  - Outputs while in reset: o_imem_req=0, o_deq_valid=0, o_empty=1, o_full=0, o_count=0, o_deq_instr=NOP, o_deq_pc=0, o_deq_pc4=0, o_imem_addr=RESET_PC.
  - Reset overrides redirect.
- Memory wait states: with i_imem_ack=0, pc_q holds and o_imem_req stays high. No duplicate or skipped entries.

## Timing
- Memory is combinational from the block's view. Address presented in cycle N, ack and instr sampled at the end of cycle N.
- Fetch-to-head latency: 1 cycle. Instruction acked in cycle N appears on o_deq_* in N+1 if the queue was empty.
- Redirect asserted in cycle N:
  - cycle N+1: o_empty=1, o_imem_addr=target;
  - cycle N+2: earliest o_deq_valid, carrying the target instruction.
- Sustained throughput: 1 instr/cycle when ack=1 and ready=1 every cycle.
- All outputs except o_imem_req are functions of registered state only. o_imem_req also depends on i_rstn and i_redirect_valid.

## Test plan
- Reset then free-run, DEPTH=4, RESET_PC=0, ack=1, ready=1, memory returns instr=addr^32'hA5A5_0000 -> o_deq_pc sequence 0,4,8,… from cycle 2. o_deq_pc4=pc+4. o_count stays 1.
- Fill: ready=0, ack=1 -> count 1,2,3,4, then o_full=1, o_imem_req=0, o_imem_addr=16. Then ready=1 -> heads 0,4,8,12 in order; fetch resumes at 16 the cycle after full deasserts.
- Wait states: ack toggled 1,0,0,1 -> exactly two entries, PCs 0 and 4. pc_q holds during ack=0.
- Redirect with 3 entries queued, i_redirect_pc=0x103 and simultaneous ready=1 -> next cycle count=0, o_deq_valid=0, o_imem_addr=0x100. Two cycles later head pc=0x100.
- Wrap: RESET_PC=0xFFFFFFF8, free-run -> pcs 0xFFFFFFF8, 0xFFFFFFFC, 0x0. The 0xFFFFFFFC entry has pc4=0. Pointers wrap over ≥3 fills of DEPTH with no corruption.
- Reset mid-operation with count=3 and redirect also asserted -> next cycle count=0, o_imem_addr=RESET_PC, all outputs at reset values.
